// File: rtl/psum_col_collector.sv
// rtl/psum_col_collector.sv - per-column psum FIFOs re-aligned into full rows
// Columns arrive skewed; the shared read pointer pairs the k-th write of every column.
module psum_col_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_overflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(depth);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [psum_bw-1:0]     mem_q  [col][depth];
  logic [AW-1:0]          wptr_q [col];
  logic [AW-1:0]          wptr_d [col];
  logic [AW:0]            cnt_q  [col];
  logic [AW:0]            cnt_d  [col];
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [psum_bw*col-1:0] out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic [col-1:0] nonempty;
  logic [col-1:0] at_full;
  logic [col-1:0] accept;
  logic [col-1:0] drop;
  logic           pop;

  always_comb begin
    nonempty = '0;
    at_full  = '0;
    for (int c = 0; c < col; c++) begin
      nonempty[c] = (cnt_q[c] != '0);
      at_full[c]  = (cnt_q[c] == DEPTH_C);
    end
  end

  assign o_ready = &nonempty;
  assign o_full  = |at_full;
  assign pop     = rd & o_ready;

  // A pop in the same cycle frees one slot, so a full column can still accept.
  always_comb begin
    accept = '0;
    drop   = '0;
    for (int c = 0; c < col; c++) begin
      accept[c] = wr[c] & (~at_full[c] | pop);
      drop[c]   = wr[c] & at_full[c] & ~pop;
    end
  end

  always_comb begin
    for (int c = 0; c < col; c++) begin
      wptr_d[c] = wptr_q[c];
      cnt_d[c]  = cnt_q[c];
      if (accept[c]) begin
        wptr_d[c] = wptr_q[c] + PTR_ONE;
      end
      case ({accept[c], pop})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
    rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
    out_d   = out_q;
    if (pop) begin
      for (int c = 0; c < col; c++) begin
        out_d[c*psum_bw +: psum_bw] = mem_q[c][rptr_q];
      end
    end
    valid_d = pop;
    ovf_d   = ovf_q | (|drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      rptr_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= wptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      rptr_q  <= rptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the counts clear.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (!reset && accept[c]) begin
        mem_q[c][wptr_q[c]] <= in[c*psum_bw +: psum_bw];
      end
    end
  end

  assign out        = out_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_psum_col_collector.sv
// tb/tb_psum_col_collector.sv - directed bench with queue-based row model
module tb_psum_col_collector;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [BW*COL-1:0] in_v;
  logic [COL-1:0]    wr_v;
  logic              rd_v;
  logic              full_o, ready_o, valid_o, ovf_o;
  logic [BW*COL-1:0] out_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0]     mq [COL][$];
  logic [BW*COL-1:0] m_out;
  logic              m_valid, m_ovf;

  psum_col_collector #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in(in_v), .wr(wr_v), .rd(rd_v),
    .o_full(full_o), .o_ready(ready_o), .o_valid(valid_o),
    .out(out_o), .o_overflow(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW*COL-1:0] act, input logic [BW*COL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEP) return 1'b1;
    return 1'b0;
  endfunction

  // Row-level model: each column is a bounded queue; a pop takes the head of every queue.
  task automatic model_step();
    logic pop;
    if (reset) begin
      for (int c = 0; c < COL; c++) mq[c].delete();
      m_out = '0; m_valid = 1'b0; m_ovf = 1'b0;
      return;
    end
    pop = rd_v && m_ready();
    m_valid = pop;
    if (pop) for (int c = 0; c < COL; c++) m_out[c*BW +: BW] = mq[c].pop_front();
    for (int c = 0; c < COL; c++) begin
      if (wr_v[c]) begin
        if (mq[c].size() < DEP) mq[c].push_back(in_v[c*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    chk("ready", {127'd0, ready_o}, {127'd0, m_ready()});
    chk("full",  {127'd0, full_o},  {127'd0, m_full()});
    chk("valid", {127'd0, valid_o}, {127'd0, m_valid});
    chk("ovf",   {127'd0, ovf_o},   {127'd0, m_ovf});
    chk("out",   out_o, m_out);
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr_v = '0; rd_v = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_v = '1; rd_v = 1'b1; in_v = {8{16'hDEAD}};
    tick();
    idle();
  endtask

  initial begin
    m_out = '0; m_valid = 1'b0; m_ovf = 1'b0;
    reset = 1'b1; wr_v = '1; rd_v = 1'b1; in_v = {8{16'h1234}};
    tick(); tick();
    idle(); tick();
    chk("rst_ready", {127'd0, ready_o}, '0);
    chk("rst_full",  {127'd0, full_o},  '0);
    chk("rst_valid", {127'd0, valid_o}, '0);
    chk("rst_ovf",   {127'd0, ovf_o},   '0);
    chk("rst_out",   out_o, '0);

    // Skewed single row
    for (int c = 0; c < COL; c++) begin
      wr_v = COL'(1) << c; in_v = '0; in_v[c*BW +: BW] = 16'h0100 + 16'(c);
      tick();
      chk("skew_ready", {127'd0, ready_o}, {127'd0, (c == COL-1)});
    end
    idle(); rd_v = 1'b1; tick(); rd_v = 1'b0;
    chk("skew_valid", {127'd0, valid_o}, 128'd1);
    chk("skew_out", out_o, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    tick();
    chk("skew_valid_drop", {127'd0, valid_o}, '0);
    chk("skew_out_hold", out_o, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

    // Three rows staggered diagonally, then back-to-back pops
    for (int t = 0; t < 3 + COL - 1; t++) begin
      wr_v = '0; in_v = '0;
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c < 3) begin
          wr_v[c] = 1'b1;
          in_v[c*BW +: BW] = 16'((t - c) * 256 + c);
        end
      end
      tick();
    end
    idle(); rd_v = 1'b1;
    tick(); chk("diag_row0", out_o, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    tick(); chk("diag_row1", out_o, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    tick(); chk("diag_row2", out_o, 128'h0207_0206_0205_0204_0203_0202_0201_0200);
    chk("diag_ready_low", {127'd0, ready_o}, '0);
    rd_v = 1'b0; tick();

    // Column 0 overflow
    do_reset();
    for (int k = 1; k <= DEP + 1; k++) begin
      wr_v = 8'h01; in_v = '0; in_v[BW-1:0] = 16'(k);
      tick();
      if (k == DEP) begin
        chk("ovf_full", {127'd0, full_o}, 128'd1);
        chk("ovf_pre",  {127'd0, ovf_o},  '0);
      end
    end
    idle(); tick();
    chk("ovf_set", {127'd0, ovf_o}, 128'd1);
    chk("ovf_full_hold", {127'd0, full_o}, 128'd1);

    // Pop and write together while full
    do_reset();
    for (int r = 0; r < DEP; r++) begin
      wr_v = '1;
      for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = 16'(r * 16 + c);
      tick();
    end
    wr_v = '1; rd_v = 1'b1; in_v = {8{16'hAAAA}}; tick();
    chk("sim_out0", out_o, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("sim_full", {127'd0, full_o}, 128'd1);
    chk("sim_ovf",  {127'd0, ovf_o}, '0);
    wr_v = '0;
    for (int k = 1; k <= DEP; k++) tick();
    chk("sim_aaaa", out_o, {8{16'hAAAA}});
    idle(); tick();

    // Streaming across pointer wrap
    do_reset();
    for (int k = 0; k < 40; k++) begin
      wr_v = '1; rd_v = 1'b1;
      for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = 16'(k * 8 + c);
      tick();
    end
    wr_v = '0; tick();
    chk("wrap_last", out_o, 128'h013F_013E_013D_013C_013B_013A_0139_0138);
    idle(); tick();

    // Reset with rows buffered
    for (int k = 0; k < 5; k++) begin
      wr_v = '1; in_v = {8{16'(k)}}; tick();
    end
    do_reset();
    chk("mid_ready", {127'd0, ready_o}, '0);
    wr_v = '1; in_v = {8{16'h5A5A}}; tick();
    wr_v = '0; rd_v = 1'b1; tick();
    chk("mid_out", out_o, {8{16'h5A5A}});
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_col_collector.md
Name: psum_col_collector

Overview:
- Output-side collector at the south edge of the MAC array. Consumes each column's partial-sum bus and per-column valid strobe, which arrive skewed by one cycle per column.
- Buffers every column in its own FIFO and re-aligns the columns into full rows.
- A single read returns one complete, column-aligned row of psums to the downstream SFU/memory writer.

Parameters:
- col, 8, number of array columns (one FIFO per column)
- psum_bw, 16, width of one column's partial sum
- depth, 16, entries per column FIFO; power of two, at least 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  psum_bw*col  column psums; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- wr  input  col  per-column write strobe (the array row's valid bits); wr[c] qualifies column c of in
- rd  input  1  request to pop one aligned row
- o_full  output  1  high when any column FIFO holds depth entries
- o_ready  output  1  high when every column FIFO holds at least one entry
- o_valid  output  1  one-cycle pulse; out holds a newly popped row
- out  output  psum_bw*col  popped row; column c occupies the same bit positions as in
- o_overflow  output  1  sticky; set when a write is dropped

Behaviour:
- Reset values:
  - all read/write pointers 0, all counts 0
  - o_full=0, o_ready=0, o_valid=0, out=0, o_overflow=0
- FIFO state:
  - each column has its own write pointer (log2(depth) bits) and a count (log2(depth)+1 bits)
  - all columns share one read pointer, because reads always pop every column together
  - pointers wrap modulo depth
- Write, per column c, at the clock edge:
  - if wr[c]=1 and (count[c]<depth, or a pop happens in the same cycle), then in[c] is stored at wptr[c] and wptr[c] increments
  - if wr[c]=1, count[c]=depth and no pop happens, the write is dropped, count is unchanged and o_overflow is set
  - columns are fully independent; any subset of wr bits may be high in a cycle
- Pop (read):
  - a pop happens when rd=1 and o_ready=1
  - a pop reads the entry at the shared read pointer from every column, then increments the read pointer
  - every count decrements, except in columns written in the same cycle, whose count stays unchanged
  - rd while o_ready=0 is ignored: no state change, o_valid stays 0
- Output timing:
  - out is registered and updates on the edge that performs the pop
  - o_valid=1 for exactly the following cycle
  - out holds its value until the next pop; it is not cleared
  - back-to-back pops are allowed, one per cycle, while o_ready stays 1
- Status flags:
  - o_ready and o_full are combinational from the counts; o_ready therefore reflects the state after the last edge
  - no write-through: a write into an empty column cannot be popped in the same cycle
- Skew handling: column c's k-th write always pairs with the k-th write of every other column, regardless of arrival cycle; no timestamps are used.
- Reset mid-operation: on the reset edge all buffered data is discarded and every output returns to its reset value; wr and rd in that cycle are ignored.
- o_overflow clears only on reset.

Test Plan:
- Reset check: hold reset 2 cycles with wr=all ones and rd=1 -> o_ready=0, o_full=0, o_valid=0, out=0 and o_overflow=0 on the cycle after reset is released.
- Skewed fill (col=8): drive wr[c] at cycle t0+c with psum value 16'h0100+c, then rd=1 -> o_ready rises only after column 7 is written; after the pop, out = {16'h0107,...,16'h0100} and o_valid pulses exactly 1 cycle.
- Skew depth: write 3 rows staggered diagonally with values 16'hR0C (R = row, C = column), then issue 3 back-to-back rd -> out = row0, row1, row2 on consecutive cycles with o_valid high for 3 cycles; o_ready falls after the third pop.
- Full/overflow: write column 0 depth+1 times with 1..17 (depth=16) while the other columns stay empty -> o_full=1 after the 16th write; the 17th write is dropped and o_overflow=1; count[0] stays 16.
- Simultaneous pop and write at full: fill all columns to 16, then rd=1 with wr=all ones carrying 16'hAAAA -> the write is accepted, the counts stay 16, no overflow, and 16'hAAAA appears as the 16th subsequent pop.
- Wrap and mid-run reset:
  - stream 40 rows through with continuous write and read -> every row is read in order, with no loss or duplication across pointer wrap
  - assert reset with 5 rows buffered -> o_ready=0 afterwards, and the next row written and popped is the first returned
